// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling FSM, and a single-word
// valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rxsig,
    output logic [DATA_WIDTH-1:0] rxdata,
    output logic                  rxvalid,
    input  logic                  rxready,
    output logic                  ferr,
    output logic                  overrun
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;
    localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PULSE_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    if (PULSE_WIDTH < 4) begin : g_pulse_chk
        $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   rxdata_q, rxdata_d;
    logic                    rxvalid_q, rxvalid_d;
    logic                    ferr_q, ferr_d;
    logic                    overrun_q, overrun_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic                    hist_q, hist_d;
    logic                    frame_good;
    logic                    frame_bad;
    logic                    handshake;

    // Synchroniser chain; only sync2_q and hist_q are ever looked at.
    always_comb begin
        sync1_d = rxsig;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (hist_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = CNT_HALF;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!sync2_q) begin
                        state_d = DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = sync2_q;
                    cnt_d          = CNT_FULL;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    frame_good = sync2_q;
                    frame_bad  = !sync2_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A finished frame may replace the held word only if that word is leaving this cycle.
    always_comb begin
        handshake = rxvalid_q && rxready;
        rxdata_d  = rxdata_q;
        rxvalid_d = rxvalid_q;
        ferr_d    = frame_bad;
        overrun_d = 1'b0;
        if (frame_good) begin
            if (!rxvalid_q || handshake) begin
                rxdata_d  = shift_q;
                rxvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            rxvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            hist_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            hist_q    <= hist_d;
        end
    end

    // Every bit is rewritten before a frame can complete, so the shifter needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rxdata  = rxdata_q;
    assign rxvalid = rxvalid_q;
    assign ferr    = ferr_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit: good frames, glitch, framing
// error with break, overrun, simultaneous handshake, and mid-frame reset.
module tb_uart_rx;

    localparam int NONE = -100;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rxsig;
    logic       rxready;
    logic       rxvalid;
    logic       ferr;
    logic       overrun;
    logic [7:0] rxdata;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (100_000),
        .CLK_FREQ  (1_000_000)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .rxsig  (rxsig),
        .rxdata (rxdata),
        .rxvalid(rxvalid),
        .rxready(rxready),
        .ferr   (ferr),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Activity monitor, sampled on the falling edge.
    int         v_cyc = 0;
    int         f_cyc = 0;
    int         o_cyc = 0;
    int         hs_n  = 0;
    logic [7:0] hs_log [0:63];
    int         b_v, b_f, b_o, b_h;

    always @(negedge clk) begin
        if (rxvalid) v_cyc <= v_cyc + 1;
        if (ferr) f_cyc <= f_cyc + 1;
        if (overrun) o_cyc <= o_cyc + 1;
        if (rxvalid && rxready && hs_n < 64) begin
            hs_log[hs_n] <= rxdata;
            hs_n         <= hs_n + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_v = v_cyc;
        b_f = f_cyc;
        b_o = o_cyc;
        b_h = hs_n;
    endtask

    // One 100-cycle frame; rdy_at/rst_at raise rxready / pulse rstn low for two edges at that cycle.
    task automatic send(input logic [7:0] d, input logic stop, input int rdy_at, input int rst_at);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int c = 0; c < 100; c++) begin
            rxsig = fr[4'(c / 10)];
            if (c == rdy_at) rxready = 1'b1;
            if (c == rst_at) rstn = 1'b0;
            if (c == rst_at + 2) rstn = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rxsig   = 1'b1;
        rxready = 1'b1;
        rstn    = 1'b0;
        tick(3);
        chk("reset_rxvalid", int'(rxvalid), 0);
        chk("reset_rxdata", int'(rxdata), 0);
        chk("reset_ferr", int'(ferr), 0);
        chk("reset_overrun", int'(overrun), 0);
        rstn = 1'b1;
        tick(10);

        // Plain frame with consumer ready
        snap();
        send(8'hA5, 1'b1, NONE, NONE);
        tick(5);
        chk("a5_handshakes", hs_n - b_h, 1);
        chk("a5_data", int'(hs_log[b_h]), 'hA5);
        chk("a5_valid_cycles", v_cyc - b_v, 1);
        chk("a5_ferr", f_cyc - b_f, 0);
        chk("a5_overrun", o_cyc - b_o, 0);

        // Short low glitch must be rejected
        snap();
        rxsig = 1'b0;
        tick(3);
        rxsig = 1'b1;
        tick(20);
        chk("glitch_valid", v_cyc - b_v, 0);
        chk("glitch_ferr", f_cyc - b_f, 0);
        snap();
        send(8'h5A, 1'b1, NONE, NONE);
        tick(5);
        chk("5a_handshakes", hs_n - b_h, 1);
        chk("5a_data", int'(hs_log[b_h]), 'h5A);

        // Framing error followed by a held break
        snap();
        send(8'h3C, 1'b0, NONE, NONE);
        tick(30);
        chk("brk_ferr_cycles", f_cyc - b_f, 1);
        chk("brk_valid", v_cyc - b_v, 0);
        chk("brk_overrun", o_cyc - b_o, 0);
        rxsig = 1'b1;
        tick(10);
        snap();
        send(8'h01, 1'b1, NONE, NONE);
        tick(5);
        chk("01_handshakes", hs_n - b_h, 1);
        chk("01_data", int'(hs_log[b_h]), 'h01);
        chk("01_ferr", f_cyc - b_f, 0);

        // Overrun: second word dropped while first is held
        rxready = 1'b0;
        snap();
        send(8'h11, 1'b1, NONE, NONE);
        send(8'h22, 1'b1, NONE, NONE);
        tick(5);
        chk("ovr_rxvalid", int'(rxvalid), 1);
        chk("ovr_rxdata", int'(rxdata), 'h11);
        chk("ovr_pulses", o_cyc - b_o, 1);
        chk("ovr_ferr", f_cyc - b_f, 0);
        chk("ovr_no_hs", hs_n - b_h, 0);
        rxready = 1'b1;
        tick(2);
        chk("ovr_valid_fall", int'(rxvalid), 0);
        chk("ovr_hs_count", hs_n - b_h, 1);
        chk("ovr_hs_data", int'(hs_log[b_h]), 'h11);

        // Handshake in the very cycle the second frame completes
        rxready = 1'b0;
        snap();
        send(8'h11, 1'b1, NONE, NONE);
        send(8'h22, 1'b1, 97, NONE);
        tick(5);
        chk("sim_hs_count", hs_n - b_h, 2);
        chk("sim_first", int'(hs_log[b_h]), 'h11);
        chk("sim_second", int'(hs_log[b_h + 1]), 'h22);
        chk("sim_overrun", o_cyc - b_o, 0);
        chk("sim_valid_fall", int'(rxvalid), 0);

        // Reset during data bit 4 abandons the frame
        snap();
        send(8'hFF, 1'b1, NONE, 52);
        tick(5);
        chk("rst_rxdata", int'(rxdata), 0);
        chk("rst_valid", v_cyc - b_v, 0);
        chk("rst_ferr", f_cyc - b_f, 0);
        chk("rst_overrun", o_cyc - b_o, 0);
        snap();
        send(8'h81, 1'b1, NONE, NONE);
        tick(5);
        chk("81_handshakes", hs_n - b_h, 1);
        chk("81_data", int'(hs_log[b_h]), 'h81);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
